// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forward-select codes and the hard-wired zero register.
package pipe_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Register $0 is never a real producer, so it never matches.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational bypass selection for the D-stage compare operands and the
// E-stage ALU operands. M results take priority over W results.
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwrite_enM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwrite_enW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE
);

  function automatic logic hit(input logic [REG_AW-1:0] src,
                               input logic [REG_AW-1:0] dst,
                               input logic              wen);
    return wen && (src != REG_AW'(REG_ZERO)) && (src == dst);
  endfunction

  function automatic logic [1:0] sel_e(input logic [REG_AW-1:0] src);
    if (hit(src, writeregM, regwrite_enM)) return FWD_M;
    if (hit(src, writeregW, regwrite_enW)) return FWD_W;
    return FWD_RF;
  endfunction

  assign forwardaD = hit(rsD, writeregM, regwrite_enM);
  assign forwardbD = hit(rtD, writeregM, regwrite_enM);
  assign forwardaE = sel_e(rsE);
  assign forwardbE = sel_e(rtE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline. Flushes that arrive
// while a long-latency stall is active are held and replayed on release.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MTR_W       = 2,
  parameter int PERF_W      = 16,
  parameter int BR_STALL_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jumprD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwrite_enE,
  input  logic [MTR_W-1:0]  memtoregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwrite_enM,
  input  logic [MTR_W-1:0]  memtoregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwrite_enW,
  input  logic              i_stall,
  input  logic              d_stall,
  input  logic              stall_divE,
  input  logic              mispredictE,
  input  logic              exceptionM,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              longest_stall,
  output logic [PERF_W-1:0] stall_cnt
);

  state_e            state_q, state_d;
  logic              pend_exc_q, pend_exc_d;
  logic              pend_mis_q, pend_mis_d;
  logic [PERF_W-1:0] cnt_q, cnt_d;

  logic matchE, matchM, lwstall, brstall, jrstall, dstall;
  logic replay, exc, mis;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .rsD          (rsD),
    .rtD          (rtD),
    .rsE          (rsE),
    .rtE          (rtE),
    .writeregM    (writeregM),
    .regwrite_enM (regwrite_enM),
    .writeregW    (writeregW),
    .regwrite_enW (regwrite_enW),
    .forwardaD    (forwardaD),
    .forwardbD    (forwardbD),
    .forwardaE    (forwardaE),
    .forwardbE    (forwardbE)
  );

  assign matchE = (writeregE != REG_AW'(REG_ZERO)) &&
                  ((writeregE == rsD) || (writeregE == rtD));
  assign matchM = (writeregM != REG_AW'(REG_ZERO)) &&
                  ((writeregM == rsD) || (writeregM == rtD));

  assign lwstall = (memtoregE != '0) && matchE;
  assign brstall = (BR_STALL_EN != 0) && branchD &&
                   ((regwrite_enE && matchE) || ((memtoregM != '0) && matchM));
  assign jrstall = jumprD && regwrite_enE && (writeregE != REG_AW'(REG_ZERO)) &&
                   (writeregE == rsD);
  assign dstall  = lwstall | brstall | jrstall;

  assign longest_stall = i_stall | d_stall | stall_divE;
  assign stall_cnt     = cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      pend_exc_q <= 1'b0;
      pend_mis_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_exc_q <= pend_exc_d;
      pend_mis_q <= pend_mis_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (longest_stall)  state_d = ST_HOLD;
      ST_HOLD: if (!longest_stall) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Pending requests accumulate only while stalled and are consumed on release.
  always_comb begin
    pend_exc_d = 1'b0;
    pend_mis_d = 1'b0;
    cnt_d      = cnt_q;
    if (longest_stall) begin
      pend_exc_d = pend_exc_q | exceptionM;
      pend_mis_d = pend_mis_q | mispredictE;
      cnt_d      = sat_inc(cnt_q);
    end
  end

  assign replay = (state_q == ST_HOLD) && !longest_stall;
  assign exc    = exceptionM | (replay & pend_exc_q);
  assign mis    = (mispredictE | (replay & pend_mis_q)) & ~exc;

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushF = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (longest_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else begin
      stallF = dstall & ~exc;
      stallD = dstall & ~exc;
      flushF = exc;
      flushD = exc | mis;
      flushE = exc | dstall;
      flushM = exc;
      flushW = exc;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: hand-derived vector table, directed multi-cycle
// sequences, then randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, jumprD, regwrite_enE, regwrite_enM, regwrite_enW;
  logic [1:0] memtoregE, memtoregM;
  logic       i_stall, d_stall, stall_divE, mispredictE, exceptionM;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushF, flushD, flushE, flushM, flushW;
  logic       longest_stall;
  logic [3:0] stall_cnt;

  pipe_hazard_ctrl #(.REG_AW(5), .MTR_W(2), .PERF_W(4), .BR_STALL_EN(1)) dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumprD(jumprD),
    .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .regwrite_enE(regwrite_enE), .memtoregE(memtoregE),
    .writeregM(writeregM), .regwrite_enM(regwrite_enM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwrite_enW(regwrite_enW),
    .i_stall(i_stall), .d_stall(d_stall), .stall_divE(stall_divE),
    .mispredictE(mispredictE), .exceptionM(exceptionM),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .longest_stall(longest_stall), .stall_cnt(stall_cnt)
  );

  wire [4:0] st_v  = {stallF, stallD, stallE, stallM, stallW};
  wire [4:0] fl_v  = {flushF, flushD, flushE, flushM, flushW};
  wire [5:0] fwd_v = {forwardaD, forwardbD, forwardaE, forwardbE};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, weE, wrM, wrW;
    logic       brD, jrD, rwE, rwM, rwW;
    logic [1:0] mtrE, mtrM;
    logic [2:0] lng;
    logic       mis, exc;
    logic [4:0] st, fl;
    logic [5:0] fwd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {branchD, jumprD, regwrite_enE, regwrite_enM, regwrite_enW} = '0;
    memtoregE = '0; memtoregM = '0;
    {i_stall, d_stall, stall_divE, mispredictE, exceptionM} = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeregE = v.weE; writeregM = v.wrM; writeregW = v.wrW;
    branchD = v.brD; jumprD = v.jrD;
    regwrite_enE = v.rwE; regwrite_enM = v.rwM; regwrite_enW = v.rwW;
    memtoregE = v.mtrE; memtoregM = v.mtrM;
    {i_stall, d_stall, stall_divE} = v.lng;
    mispredictE = v.mis; exceptionM = v.exc;
  endtask

  // Reference model state: pending requests and stall-cycle count.
  bit m_pe, m_pm;
  int m_cnt;

  function automatic bit reg_hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] m_fwdE(input logic [4:0] src);
    if (regwrite_enM && reg_hit(src, writeregM)) return 2'b10;
    if (regwrite_enW && reg_hit(src, writeregW)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_check(input string tag);
    bit ls, uses_e, uses_m, lw, br, jr, ds, ex, ms;
    logic [4:0] est, efl;
    ls     = i_stall || d_stall || stall_divE;
    uses_e = reg_hit(writeregE, rsD) || reg_hit(writeregE, rtD);
    uses_m = reg_hit(writeregM, rsD) || reg_hit(writeregM, rtD);
    lw     = (memtoregE != 0) && uses_e;
    br     = branchD && ((regwrite_enE && uses_e) || ((memtoregM != 0) && uses_m));
    jr     = jumprD && regwrite_enE && reg_hit(writeregE, rsD);
    ds     = lw || br || jr;
    ex     = exceptionM || m_pe;
    ms     = (mispredictE || m_pm) && !ex;
    if (ls) begin
      est = 5'b11111;
      efl = 5'b00000;
    end else begin
      est = {ds && !ex, ds && !ex, 3'b000};
      efl = {ex, ex || ms, ex || ds, ex, ex};
    end
    chk({tag, " stall"}, 32'(st_v), 32'(est));
    chk({tag, " flush"}, 32'(fl_v), 32'(efl));
    chk({tag, " fwd"}, 32'(fwd_v),
        32'({regwrite_enM && reg_hit(rsD, writeregM), regwrite_enM && reg_hit(rtD, writeregM),
             m_fwdE(rsE), m_fwdE(rtE)}));
    chk({tag, " longest"}, 32'(longest_stall), 32'(ls));
    chk({tag, " cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic model_step();
    if (!resetn) begin
      m_pe = 0; m_pm = 0; m_cnt = 0;
    end else if (i_stall || d_stall || stall_divE) begin
      m_pe = m_pe || exceptionM;
      m_pm = m_pm || mispredictE;
      m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    end else begin
      m_pe = 0; m_pm = 0;
    end
  endtask

  initial begin
    vec_t v;
    resetn = 1'b0;
    clr();

    // ---------------- vector table ----------------
    v = '0; v.mtrE = 2'b01; v.weE = 8; v.rsD = 8; v.st = 5'b11000; v.fl = 5'b00100; vt.push_back(v);
    v = '0; v.rsE = 9; v.wrM = 9; v.rwM = 1; v.wrW = 9; v.rwW = 1; v.fwd = 6'b001000; vt.push_back(v);
    v = '0; v.rsE = 0; v.wrM = 9; v.rwM = 1; v.wrW = 9; v.rwW = 1; v.fwd = 6'b000000; vt.push_back(v);
    v = '0; v.rtE = 9; v.wrW = 9; v.rwW = 1; v.fwd = 6'b000001; vt.push_back(v);
    v = '0; v.jrD = 1; v.rwE = 1; v.weE = 31; v.rsD = 31; v.st = 5'b11000; v.fl = 5'b00100; vt.push_back(v);
    v = '0; v.jrD = 1; v.rwE = 1; v.weE = 0; v.rsD = 31; vt.push_back(v);
    v = '0; v.brD = 1; v.rwE = 1; v.weE = 5; v.rtD = 5; v.st = 5'b11000; v.fl = 5'b00100; vt.push_back(v);
    v = '0; v.brD = 1; v.mtrM = 2; v.wrM = 6; v.rsD = 6; v.st = 5'b11000; v.fl = 5'b00100; vt.push_back(v);
    v = '0; v.brD = 0; v.rwE = 1; v.weE = 5; v.rtD = 5; vt.push_back(v);
    v = '0; v.mis = 1; v.fl = 5'b01000; vt.push_back(v);
    v = '0; v.exc = 1; v.fl = 5'b11111; vt.push_back(v);
    v = '0; v.exc = 1; v.mtrE = 1; v.weE = 8; v.rsD = 8; v.fl = 5'b11111; vt.push_back(v);
    v = '0; v.mis = 1; v.exc = 1; v.fl = 5'b11111; vt.push_back(v);
    v = '0; v.lng = 3'b100; v.st = 5'b11111; vt.push_back(v);
    v = '0; v.lng = 3'b001; v.mis = 1; v.mtrE = 1; v.weE = 8; v.rsD = 8; v.st = 5'b11111; vt.push_back(v);
    v = '0; v.rsD = 7; v.rtD = 7; v.wrM = 7; v.rwM = 1; v.fwd = 6'b110000; vt.push_back(v);
    v = '0; v.mis = 1; v.mtrE = 1; v.weE = 8; v.rtD = 8; v.st = 5'b11000; v.fl = 5'b01100; vt.push_back(v);

    foreach (vt[i]) begin
      do_reset();
      apply_vec(vt[i]);
      #1;
      chk($sformatf("vec%0d stall", i), 32'(st_v), 32'(vt[i].st));
      chk($sformatf("vec%0d flush", i), 32'(fl_v), 32'(vt[i].fl));
      chk($sformatf("vec%0d fwd", i), 32'(fwd_v), 32'(vt[i].fwd));
      chk($sformatf("vec%0d longest", i), 32'(longest_stall), 32'(vt[i].lng != 0));
      cyc();
    end

    // ---------------- load-use then forward from M ----------------
    do_reset();
    chk("reset cnt", 32'(stall_cnt), 32'd0);
    memtoregE = 2'b01; writeregE = 8; rsD = 8; #1;
    chk("lu stallD", 32'(stallD), 32'd1);
    cyc();
    clr(); rsE = 8; writeregM = 8; regwrite_enM = 1; memtoregM = 2'b01; #1;
    chk("lu next stall", 32'(st_v), 32'd0);
    chk("lu next flushE", 32'(flushE), 32'd0);
    chk("lu next fwdaE", 32'(forwardaE), 32'b10);
    cyc();

    // ---------------- exception during d-cache stall ----------------
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      clr(); d_stall = 1; exceptionM = (c == 2); #1;
      chk($sformatf("dexc c%0d flush", c), 32'(fl_v), 32'd0);
      chk($sformatf("dexc c%0d stall", c), 32'(st_v), 32'h1f);
      cyc();
    end
    clr(); #1;
    chk("dexc release flush", 32'(fl_v), 32'h1f);
    chk("dexc release stall", 32'(st_v), 32'd0);
    cyc();
    #1;
    chk("dexc after flush", 32'(fl_v), 32'd0);
    cyc();

    // ---------------- mispredict + exception both pending ----------------
    do_reset();
    clr(); i_stall = 1; mispredictE = 1; #1; cyc();
    clr(); i_stall = 1; exceptionM = 1; #1; cyc();
    clr(); i_stall = 1; #1; cyc();
    clr(); #1;
    chk("both release flushM", 32'(flushM), 32'd1);
    chk("both release flush", 32'(fl_v), 32'h1f);
    cyc();
    #1;
    chk("both after", 32'(fl_v), 32'd0);

    // ---------------- mispredict only pending ----------------
    clr(); stall_divE = 1; mispredictE = 1; #1; cyc();
    clr(); #1;
    chk("mis release flush", 32'(fl_v), 32'b01000);
    cyc();
    #1;
    chk("mis after", 32'(fl_v), 32'd0);

    // ---------------- request in the release cycle is not latched ----------------
    clr(); d_stall = 1; #1; cyc();
    clr(); exceptionM = 1; #1;
    chk("fall-cycle exc", 32'(fl_v), 32'h1f);
    cyc();
    clr(); #1;
    chk("fall-cycle after", 32'(fl_v), 32'd0);
    cyc();

    // ---------------- reset during HOLD drops pending flush ----------------
    do_reset();
    clr(); d_stall = 1; exceptionM = 1; #1; cyc();
    clr(); d_stall = 1; resetn = 1'b0; #1; cyc();
    resetn = 1'b1; clr(); #1;
    chk("rst hold flush", 32'(fl_v), 32'd0);
    chk("rst hold cnt", 32'(stall_cnt), 32'd0);
    cyc();

    // ---------------- saturating counter ----------------
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      clr(); stall_divE = 1; cyc();
      if (c == 3) chk("cnt 3", 32'(stall_cnt), 32'd3);
      if (c == 15) chk("cnt 15", 32'(stall_cnt), 32'd15);
    end
    chk("cnt sat", 32'(stall_cnt), 32'd15);
    clr(); resetn = 1'b0; cyc();
    resetn = 1'b1; #1;
    chk("cnt reset", 32'(stall_cnt), 32'd0);
    chk("reset run flush", 32'(fl_v), 32'd0);
    cyc();

    // ---------------- randomized vs reference model ----------------
    do_reset();
    m_pe = 0; m_pm = 0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      branchD = 1'($urandom_range(0, 3) == 0);
      jumprD  = 1'($urandom_range(0, 3) == 0);
      regwrite_enE = 1'($urandom); regwrite_enM = 1'($urandom); regwrite_enW = 1'($urandom);
      memtoregE = 2'($urandom); memtoregM = 2'($urandom);
      i_stall    = 1'($urandom_range(0, 5) == 0);
      d_stall    = 1'($urandom_range(0, 5) == 0);
      stall_divE = 1'($urandom_range(0, 7) == 0);
      mispredictE = 1'($urandom_range(0, 4) == 0);
      exceptionM  = 1'($urandom_range(0, 6) == 0);
      resetn = 1'($urandom_range(0, 49) != 0);
      #1;
      model_check("rand");
      cyc();
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
